// File: rtl/wb_stage_pkg.sv
// Shared types and encodings for the writeback stage.
// Optional feature macro: WB_BYPASS_EN (rd write-port bypass to decode).
package wb_stage_pkg;

    localparam int WB_XLEN = 64;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

    typedef struct packed {
        logic [4:0]         rd;
        logic               wen;
        logic [2:0]         funct3;
        logic [2:0]         addr;
        logic [WB_XLEN-1:0] pc;
    } load_ctx_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load data alignment, sign/zero extension and misalignment detection.
// Part of wb_stage (optional macro WB_BYPASS_EN does not affect this file).
module load_ext
    import wb_stage_pkg::*;
(
    input  logic [2:0]         funct3_i,
    input  logic [2:0]         addr_i,
    input  logic [WB_XLEN-1:0] rdata_i,
    output logic [WB_XLEN-1:0] data_o,
    output logic               mis_o
);

    logic [WB_XLEN-1:0] sh;

    assign sh = rdata_i >> {addr_i, 3'b000};

    always_comb begin
        data_o = sh;
        mis_o  = 1'b0;
        unique case (funct3_i)
            F3_LB:  data_o = {{56{sh[7]}}, sh[7:0]};
            F3_LBU: data_o = {56'd0, sh[7:0]};
            F3_LH: begin
                data_o = {{48{sh[15]}}, sh[15:0]};
                mis_o  = addr_i[0];
            end
            F3_LHU: begin
                data_o = {48'd0, sh[15:0]};
                mis_o  = addr_i[0];
            end
            F3_LW: begin
                data_o = {{32{sh[31]}}, sh[31:0]};
                mis_o  = |addr_i[1:0];
            end
            F3_LWU: begin
                data_o = {32'd0, sh[31:0]};
                mis_o  = |addr_i[1:0];
            end
            // LD, and the reserved 111 encoding handled as LD
            default: begin
                data_o = sh;
                mis_o  = |addr_i;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result/load retirement, busy scoreboard, commit pulse.
// Optional macro WB_BYPASS_EN: forward the rd write port to decode sources.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN = WB_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_pc,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic            iss_rd_wen,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rs1_fwd_valid,
    output logic [XLEN-1:0] rs1_fwd_data,
    output logic            rs2_fwd_valid,
    output logic [XLEN-1:0] rs2_fwd_data,
    output logic [4:0]      rd,
    output logic            rd_wen,
    output logic [XLEN-1:0] x_rd,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic            load_misalign
);

    logic [0:0]      state_q, state_d;
    load_ctx_t       ld_q, ld_d;
    logic            ready_q, ready_d;
    logic [4:0]      rd_q, rd_d;
    logic            rd_wen_q, rd_wen_d;
    logic [XLEN-1:0] x_rd_q, x_rd_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            commit_q, commit_d;
    logic            mis_q, mis_d;
    logic [31:0]     busy_q, busy_d;
    logic [XLEN-1:0] ext_data;
    logic            ext_mis;
    logic            accept;

    load_ext u_load_ext (
        .funct3_i (ld_q.funct3),
        .addr_i   (ld_q.addr),
        .rdata_i  (mem_rdata),
        .data_o   (ext_data),
        .mis_o    (ext_mis)
    );

    // ready_q is low only out of reset and while a load is outstanding
    assign accept = in_valid & ready_q;

    always_comb begin
        state_d  = state_q;
        ld_d     = ld_q;
        rd_d     = rd_q;
        x_rd_d   = x_rd_q;
        pc_d     = pc_q;
        rd_wen_d = 1'b0;
        commit_d = 1'b0;
        mis_d    = 1'b0;
        unique case (1'b1)
            state_q == ST_IDLE: begin
                if (accept && in_is_load) begin
                    ld_d.rd     = in_rd;
                    ld_d.wen    = in_rd_wen;
                    ld_d.funct3 = in_funct3;
                    ld_d.addr   = in_result[2:0];
                    ld_d.pc     = in_pc;
                    state_d     = ST_LOAD_WAIT;
                end else if (accept) begin
                    rd_d     = in_rd;
                    rd_wen_d = in_rd_wen & (|in_rd);
                    x_rd_d   = in_result;
                    pc_d     = in_pc;
                    commit_d = 1'b1;
                end
            end
            state_q == ST_LOAD_WAIT: begin
                if (mem_rvalid) begin
                    state_d  = ST_IDLE;
                    rd_d     = ld_q.rd;
                    pc_d     = ld_q.pc;
                    commit_d = 1'b1;
                    mis_d    = ext_mis;
                    rd_wen_d = ld_q.wen & (|ld_q.rd) & ~ext_mis;
                    if (!ext_mis) begin
                        x_rd_d = ext_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready_d = (state_d == ST_IDLE);

    // clear on retirement first so a same-cycle reissue keeps the bit set
    always_comb begin
        busy_d = busy_q;
        if (commit_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (iss_valid && iss_rd_wen) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ld_q     <= '0;
            ready_q  <= 1'b0;
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
            x_rd_q   <= '0;
            pc_q     <= '0;
            commit_q <= 1'b0;
            mis_q    <= 1'b0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            ld_q     <= ld_d;
            ready_q  <= ready_d;
            rd_q     <= rd_d;
            rd_wen_q <= rd_wen_d;
            x_rd_q   <= x_rd_d;
            pc_q     <= pc_d;
            commit_q <= commit_d;
            mis_q    <= mis_d;
            busy_q   <= busy_d;
        end
    end

    assign in_ready      = ready_q;
    assign rd            = rd_q;
    assign rd_wen        = rd_wen_q;
    assign x_rd          = x_rd_q;
    assign commit_valid  = commit_q;
    assign commit_pc     = pc_q;
    assign load_misalign = mis_q;

`ifdef WB_BYPASS_EN
    assign rs1_fwd_valid = rd_wen_q & (|rd_q) & (rd_q == iss_rs1);
    assign rs2_fwd_valid = rd_wen_q & (|rd_q) & (rd_q == iss_rs2);
    assign rs1_fwd_data  = x_rd_q;
    assign rs2_fwd_data  = x_rd_q;
    assign rs1_busy      = busy_q[iss_rs1] & ~rs1_fwd_valid;
    assign rs2_busy      = busy_q[iss_rs2] & ~rs2_fwd_valid;
`else
    assign rs1_fwd_valid = 1'b0;
    assign rs2_fwd_valid = 1'b0;
    assign rs1_fwd_data  = '0;
    assign rs2_fwd_data  = '0;
    assign rs1_busy      = busy_q[iss_rs1];
    assign rs2_busy      = busy_q[iss_rs2];
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a commit scoreboard queue.
// Honours WB_BYPASS_EN when the design is built with it.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_rd_wen = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [63:0] in_result = '0;
    logic [63:0] in_pc = '0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        iss_rd_wen = 1'b0;
    logic [4:0]  iss_rs1 = '0;
    logic [4:0]  iss_rs2 = '0;
    logic        rs1_busy, rs2_busy;
    logic        rs1_fwd_valid, rs2_fwd_valid;
    logic [63:0] rs1_fwd_data, rs2_fwd_data;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [63:0] x_rd;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        load_misalign;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
        logic [63:0] x;
        logic [63:0] pc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_rd_wen     (in_rd_wen),
        .in_is_load    (in_is_load),
        .in_funct3     (in_funct3),
        .in_result     (in_result),
        .in_pc         (in_pc),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .iss_valid     (iss_valid),
        .iss_rd        (iss_rd),
        .iss_rd_wen    (iss_rd_wen),
        .iss_rs1       (iss_rs1),
        .iss_rs2       (iss_rs2),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rs1_fwd_valid (rs1_fwd_valid),
        .rs1_fwd_data  (rs1_fwd_data),
        .rs2_fwd_valid (rs2_fwd_valid),
        .rs2_fwd_data  (rs2_fwd_data),
        .rd            (rd),
        .rd_wen        (rd_wen),
        .x_rd          (x_rd),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .load_misalign (load_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r);
        iss_valid  = 1'b1;
        iss_rd     = r;
        iss_rd_wen = 1'b1;
        tick();
        iss_valid  = 1'b0;
        iss_rd_wen = 1'b0;
    endtask

    task automatic alu(input logic [4:0] r, input logic [63:0] v,
                       input logic [63:0] pc);
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_rd      = r;
        in_rd_wen  = 1'b1;
        in_result  = v;
        in_pc      = pc;
        q.push_back('{r, (r != 5'd0), 1'b0, v, pc});
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic load_op(input logic [4:0] r, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] pc,
                           input logic [63:0] rdata, input logic mis,
                           input logic [63:0] exp_x, input int waits);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = r;
        in_rd_wen  = 1'b1;
        in_funct3  = f3;
        in_result  = addr;
        in_pc      = pc;
        tick();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        for (int i = 0; i < waits; i++) begin
            chk("ready_low_wait", {63'd0, in_ready}, 64'd0);
            tick();
        end
        chk("ready_low_wait", {63'd0, in_ready}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        q.push_back('{r, (!mis && r != 5'd0), mis, exp_x, pc});
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        chk("ready_after_load", {63'd0, in_ready}, 64'd1);
    endtask

    // Scoreboard monitor: every commit pulse retires the oldest entry
    always @(negedge clk) begin
        if (rst) begin
            if (commit_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_commit", {63'd0, commit_valid}, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("commit_rd", {59'd0, rd}, {59'd0, e.rd});
                    chk("commit_rd_wen", {63'd0, rd_wen}, {63'd0, e.wen});
                    chk("commit_misalign", {63'd0, load_misalign},
                        {63'd0, e.mis});
                    chk("commit_pc", commit_pc, e.pc);
                    if (!e.mis) chk("commit_x_rd", x_rd, e.x);
                end
            end else begin
                chk("idle_pulses", {62'd0, rd_wen, load_misalign}, 64'd0);
            end
        end
    end

    initial begin
        #1;
        chk("reset_ready", {63'd0, in_ready}, 64'd0);
        chk("reset_commit", {63'd0, commit_valid}, 64'd0);
        chk("reset_rd_wen", {63'd0, rd_wen}, 64'd0);
        chk("reset_x_rd", x_rd, 64'd0);
        chk("reset_rd", {59'd0, rd}, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

        // ALU write to x5 clears its busy bit after the commit cycle
        issue(5'd5);
        iss_rs1 = 5'd5;
        #1;
        chk("busy5_set", {63'd0, rs1_busy}, 64'd1);
        alu(5'd5, 64'h1234, 64'h100);
        tick();
        chk("busy5_clear", {63'd0, rs1_busy}, 64'd0);

        // Load extension on byte 3 of 0x80000000
        load_op(5'd6, F3_LB, 64'h1003, 64'h104,
                64'h0000_0000_8000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 2);
        load_op(5'd6, F3_LBU, 64'h1003, 64'h108,
                64'h0000_0000_8000_0000, 1'b0, 64'h80, 0);
        load_op(5'd6, F3_LH, 64'h1002, 64'h10c,
                64'h0000_0000_8000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_8000, 1);
        load_op(5'd6, F3_LW, 64'h1004, 64'h110,
                64'hDEAD_BEEF_0000_0000, 1'b0, 64'hFFFF_FFFF_DEAD_BEEF, 0);
        load_op(5'd6, F3_LWU, 64'h1004, 64'h114,
                64'hDEAD_BEEF_0000_0000, 1'b0, 64'h0000_0000_DEAD_BEEF, 0);
        load_op(5'd6, 3'b111, 64'h1000, 64'h118,
                64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF, 0);

        // Stray mem_rvalid while idle must not retire anything
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFF;
        tick();
        mem_rvalid = 1'b0;
        tick();

        // Misaligned LW: misalign pulse, no write, busy cleared
        issue(5'd8);
        load_op(5'd8, F3_LW, 64'h1002, 64'h11c,
                64'h1111_2222_3333_4444, 1'b1, 64'd0, 3);
        tick();
        iss_rs2 = 5'd8;
        #1;
        chk("busy8_clear", {63'd0, rs2_busy}, 64'd0);
        load_op(5'd8, F3_LD, 64'h1004, 64'h120,
                64'h1111_2222_3333_4444, 1'b1, 64'd0, 0);

        // Back-to-back x0 and x7, reissue of x7 in its commit cycle
        issue(5'd7);
        alu(5'd0, 64'h55, 64'h200);
        alu(5'd7, 64'h77, 64'h204);
        iss_valid  = 1'b1;
        iss_rd     = 5'd7;
        iss_rd_wen = 1'b1;
        tick();
        iss_valid  = 1'b0;
        iss_rd_wen = 1'b0;
        iss_rs1    = 5'd7;
        #1;
        chk("busy7_set_wins", {63'd0, rs1_busy}, 64'd1);

        // Reset while a load is outstanding
        issue(5'd10);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = 5'd10;
        in_funct3  = F3_LD;
        in_result  = 64'h2000;
        in_pc      = 64'h300;
        tick();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_mid_busy", {63'd0, rs1_busy}, 64'd0);
        tick();
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD;
        tick();
        mem_rvalid = 1'b0;
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        iss_rs1 = 5'd10;
        iss_rs2 = 5'd7;
        #1;
        chk("rst_busy10", {63'd0, rs1_busy}, 64'd0);
        chk("rst_busy7", {63'd0, rs2_busy}, 64'd0);
        tick();

        // Bypass from the write port during the x9 write
        issue(5'd9);
        iss_rs1 = 5'd9;
        iss_rs2 = 5'd3;
        alu(5'd9, 64'hABCD, 64'h400);
`ifdef WB_BYPASS_EN
        chk("fwd1_valid", {63'd0, rs1_fwd_valid}, 64'd1);
        chk("fwd1_data", rs1_fwd_data, 64'hABCD);
        chk("fwd1_busy", {63'd0, rs1_busy}, 64'd0);
`else
        chk("fwd1_valid", {63'd0, rs1_fwd_valid}, 64'd0);
        chk("fwd1_data", rs1_fwd_data, 64'd0);
        chk("fwd1_busy", {63'd0, rs1_busy}, 64'd1);
`endif
        chk("fwd2_valid", {63'd0, rs2_fwd_valid}, 64'd0);
        tick();
        chk("busy9_clear", {63'd0, rs1_busy}, 64'd0);
        tick();

        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
